priv_trap_controller: RTL and testbench
=======================================

Name: priv_trap_controller

Overview:
- Consumes the privilege-violation flags produced by the memory/PC checker (Illegal_PC, Illegal_Memory), plus syscall and eret requests from decode.
- Owns the Mode register (1 = kernel, 0 = user) that the checker reads.
- On a violation or syscall it records the faulting PC and cause, enters kernel mode, flushes the pipeline and redirects fetch to a page-0 handler vector.
- On eret it restores the prior mode and returns to the saved PC.

Parameters:
- PC_WIDTH, 16, width of all PC values
- VEC_ILLEGAL_PC, 16'h0010, handler address for cause 0
- VEC_ILLEGAL_MEM, 16'h0020, handler address for cause 1
- VEC_SYSCALL, 16'h0030, handler address for cause 2
- VEC_PRIV_INSTR, 16'h0040, handler address for cause 3 (eret issued in user mode)
- FLUSH_CYCLES, 2, pre-redirect flush length; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- Illegal_PC  in  1  illegal jump/branch target flag from the checker
- Illegal_Memory  in  1  illegal load/store flag from the checker
- syscall  in  1  syscall instruction in execute
- eret  in  1  return-from-exception instruction in execute
- fault_pc  in  PC_WIDTH  PC of the instruction in execute
- Mode  out  1  current privilege (1 = kernel)
- trap_flush  out  1  squash all in-flight instructions
- pc_redirect  out  1  fetch loads redirect_pc this cycle
- redirect_pc  out  PC_WIDTH  target address for the redirect
- epc  out  PC_WIDTH  saved exception PC
- cause  out  2  0 = illegal PC, 1 = illegal memory, 2 = syscall, 3 = privileged instruction
- busy  out  1  high whenever state != IDLE
- trap_count  out  8  number of traps taken (see Optional Feature)

Behaviour:
- Reset values: Mode=1, prev_mode=1, epc=0, cause=0, trap_flush=0, pc_redirect=0, redirect_pc=0, busy=0, trap_count=0, state=IDLE, flush counter=0.
- Events are sampled only in IDLE. Priority: Illegal_PC > Illegal_Memory > (eret with Mode=0) > syscall > (eret with Mode=1).
- Trap event accepted at edge N:
  - epc<=fault_pc, cause<=code, prev_mode<=Mode, Mode<=1, state<=FLUSH, counter<=FLUSH_CYCLES-1.
- FLUSH state:
  - trap_flush=1, pc_redirect=0.
  - Counter decrements each cycle; at 0 go to REDIRECT.
- REDIRECT state (exactly 1 cycle):
  - trap_flush=1, pc_redirect=1, redirect_pc=vector for cause; then go to IDLE.
- Trap timing: trap_flush is high for cycles N+1 .. N+FLUSH_CYCLES+1; pc_redirect is high only in cycle N+FLUSH_CYCLES+1.
- eret in kernel mode (accepted at edge N):
  - Mode<=prev_mode, prev_mode<=1, state<=REDIRECT directly.
  - Cycle N+1: trap_flush=1, pc_redirect=1, redirect_pc=epc.
  - epc and cause are unchanged.
- eret in user mode: handled as a trap with cause 3; epc is overwritten with fault_pc.
- syscall in kernel mode is legal: epc is overwritten and prev_mode<=1, so nesting depth is 1.
- All inputs are ignored while busy=1, because the instructions raising them are being flushed.
- Multiple simultaneous inputs: only the highest-priority event is taken; the others are dropped.
- redirect_pc holds its last value when pc_redirect=0; consumers qualify it with pc_redirect.
- Reset asserted mid-FLUSH or mid-REDIRECT: on the next edge all state returns to reset values and no redirect is issued.
- busy is a registered copy of (state != IDLE), so it rises at N+1 together with trap_flush.

Optional Feature:
- Macro: PRIV_TRAP_COUNT_EN.
- Defined: trap_count is an 8-bit saturating counter, reset to 0.
  - Increments on every accepted trap (causes 0..3).
  - Does not increment on a kernel-mode eret.
  - Holds at 8'hFF once reached.
- Undefined: no counter logic; trap_count is tied to 8'h00. The port is present in both builds.

Test Plan:
- Reset, then Mode=0 via eret (prev_mode forced to 0 by a prior user trap); assert Illegal_Memory with fault_pc=16'h1234 -> cause=1, epc=16'h1234, Mode=1 at N+1, trap_flush high N+1..N+3, pc_redirect with redirect_pc=16'h0020 at N+3.
- From user mode, assert Illegal_PC and Illegal_Memory together with fault_pc=16'h2000 -> cause=0, redirect_pc=16'h0010; Illegal_Memory is dropped.
- After the above trap, issue eret at kernel mode -> next cycle pc_redirect=1, redirect_pc=16'h2000, Mode=0, trap_flush=1 for exactly one cycle.
- User-mode eret with fault_pc=16'h3004 -> cause=3, epc=16'h3004, redirect_pc=16'h0040, Mode=1.
- Assert syscall in FLUSH state and Illegal_Memory in REDIRECT state -> both ignored; exactly one pc_redirect pulse; epc unchanged.
- Assert rst during the second FLUSH cycle -> next cycle Mode=1, busy=0, trap_flush=0, no pc_redirect pulse, epc=0. With PRIV_TRAP_COUNT_EN defined, 300 traps -> trap_count=8'hFF; without the macro, trap_count=0.

Source files
------------

// File: rtl/priv_trap_controller.sv
// Privilege trap controller: owns Mode, records epc/cause, flushes and redirects fetch to trap vectors.
// Optional build macro PRIV_TRAP_COUNT_EN enables the saturating trap_count counter (tied to 0 otherwise).
module priv_trap_controller #(
    parameter int                  PC_WIDTH        = 16,
    parameter logic [PC_WIDTH-1:0] VEC_ILLEGAL_PC  = 'h0010,
    parameter logic [PC_WIDTH-1:0] VEC_ILLEGAL_MEM = 'h0020,
    parameter logic [PC_WIDTH-1:0] VEC_SYSCALL     = 'h0030,
    parameter logic [PC_WIDTH-1:0] VEC_PRIV_INSTR  = 'h0040,
    parameter int                  FLUSH_CYCLES    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Illegal_PC,
    input  logic                Illegal_Memory,
    input  logic                syscall,
    input  logic                eret,
    input  logic [PC_WIDTH-1:0] fault_pc,
    output logic                Mode,
    output logic                trap_flush,
    output logic                pc_redirect,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] epc,
    output logic [1:0]          cause,
    output logic                busy,
    output logic [7:0]          trap_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] flush_cnt;
    logic       prev_mode;
    logic       take_trap;
    logic       take_eret;
    logic [1:0] trap_code;

    function automatic logic [PC_WIDTH-1:0] vector_for(input logic [1:0] c);
        case (c)
            2'd0:    return VEC_ILLEGAL_PC;
            2'd1:    return VEC_ILLEGAL_MEM;
            2'd2:    return VEC_SYSCALL;
            default: return VEC_PRIV_INSTR;
        endcase
    endfunction

    // A user-mode eret outranks syscall because it is itself a privilege violation.
    always_comb begin
        take_trap = 1'b0;
        take_eret = 1'b0;
        trap_code = 2'd0;
        if (state == IDLE) begin
            if (Illegal_PC) begin
                take_trap = 1'b1;
                trap_code = 2'd0;
            end else if (Illegal_Memory) begin
                take_trap = 1'b1;
                trap_code = 2'd1;
            end else if (eret && !Mode) begin
                take_trap = 1'b1;
                trap_code = 2'd3;
            end else if (syscall) begin
                take_trap = 1'b1;
                trap_code = 2'd2;
            end else if (eret) begin
                take_eret = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= 4'd0;
            Mode        <= 1'b1;
            prev_mode   <= 1'b1;
            epc         <= '0;
            cause       <= 2'd0;
            redirect_pc <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        epc       <= fault_pc;
                        cause     <= trap_code;
                        prev_mode <= Mode;
                        Mode      <= 1'b1;
                        flush_cnt <= FLUSH_CNT_INIT;
                        state     <= FLUSH;
                        busy      <= 1'b1;
                    end else if (take_eret) begin
                        Mode        <= prev_mode;
                        prev_mode   <= 1'b1;
                        redirect_pc <= epc;
                        state       <= REDIRECT;
                        busy        <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        redirect_pc <= vector_for(cause);
                        state       <= REDIRECT;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign trap_flush  = (state == FLUSH) || (state == REDIRECT);
    assign pc_redirect = (state == REDIRECT);

`ifdef PRIV_TRAP_COUNT_EN
    logic [7:0] trap_cnt;

    // Saturates so software can tell "many" from a wrapped small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_cnt <= 8'h00;
        end else if (take_trap && (trap_cnt != 8'hFF)) begin
            trap_cnt <= trap_cnt + 8'h01;
        end
    end

    assign trap_count = trap_cnt;
`else
    assign trap_count = 8'h00;
`endif

endmodule

// File: tb/tb_priv_trap_controller.sv
// Testbench for priv_trap_controller: directed vector table, hand sequences and random stimulus
// checked against a cycle-budget reference model of the trap/eret rules.
module tb_priv_trap_controller;

    localparam int FC = 2;
`ifdef PRIV_TRAP_COUNT_EN
    localparam logic [7:0] EXP_SAT = 8'hFF;
`else
    localparam logic [7:0] EXP_SAT = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Illegal_PC = 1'b0;
    logic        Illegal_Memory = 1'b0;
    logic        syscall = 1'b0;
    logic        eret = 1'b0;
    logic [15:0] fault_pc = 16'h0000;
    logic        Mode;
    logic        trap_flush;
    logic        pc_redirect;
    logic [15:0] redirect_pc;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        busy;
    logic [7:0]  trap_count;

    int n_cmp = 0;
    int n_fail = 0;

    priv_trap_controller dut (
        .clk            (clk),
        .rst            (rst),
        .Illegal_PC     (Illegal_PC),
        .Illegal_Memory (Illegal_Memory),
        .syscall        (syscall),
        .eret           (eret),
        .fault_pc       (fault_pc),
        .Mode           (Mode),
        .trap_flush     (trap_flush),
        .pc_redirect    (pc_redirect),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .cause          (cause),
        .busy           (busy),
        .trap_count     (trap_count)
    );

    always #5 clk = ~clk;

    // Reference model: a trap occupies the pipeline for a fixed number of cycles,
    // the last of which is the redirect to a precomputed target.
    logic [15:0] vec_tbl [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    logic        m_mode, m_prev;
    logic [15:0] m_epc, m_rpc, m_target;
    logic [1:0]  m_cause;
    int          m_left;
    int          m_count;

    task automatic modelReset();
        m_mode = 1'b1; m_prev = 1'b1; m_epc = 16'h0; m_rpc = 16'h0;
        m_target = 16'h0; m_cause = 2'd0; m_left = 0; m_count = 0;
    endtask

    task automatic modelTrap(input logic [1:0] c, input logic [15:0] pc);
        m_epc = pc; m_cause = c; m_prev = m_mode; m_mode = 1'b1;
        m_left = FC + 1; m_target = vec_tbl[c];
        if (m_count < 255) m_count++;
    endtask

    task automatic modelStep(input logic r, input logic ipc, input logic imem,
                             input logic sys, input logic er, input logic [15:0] pc);
        if (r) begin
            modelReset();
        end else if (m_left > 0) begin
            m_left--;
        end else if (ipc) modelTrap(2'd0, pc);
        else if (imem) modelTrap(2'd1, pc);
        else if (er && !m_mode) modelTrap(2'd3, pc);
        else if (sys) modelTrap(2'd2, pc);
        else if (er) begin
            m_target = m_epc; m_mode = m_prev; m_prev = 1'b1; m_left = 1;
        end
        if (m_left == 1) m_rpc = m_target;
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compare("Mode", 32'(Mode), 32'(m_mode));
        compare("trap_flush", 32'(trap_flush), 32'(m_left > 0));
        compare("pc_redirect", 32'(pc_redirect), 32'(m_left == 1));
        compare("busy", 32'(busy), 32'(m_left > 0));
        compare("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
        compare("epc", 32'(epc), 32'(m_epc));
        compare("cause", 32'(cause), 32'(m_cause));
`ifdef PRIV_TRAP_COUNT_EN
        compare("trap_count", 32'(trap_count), 32'(m_count));
`else
        compare("trap_count", 32'(trap_count), 32'h0);
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic ipc, input logic imem,
                                 input logic sys, input logic er, input logic [15:0] pc);
        @(negedge clk);
        rst = r; Illegal_PC = ipc; Illegal_Memory = imem; syscall = sys; eret = er; fault_pc = pc;
        @(posedge clk);
        modelStep(r, ipc, imem, sys, er, pc);
        #1;
        checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // User mode is only reachable once prev_mode holds 0, so seed it directly for one eret.
    task automatic enterUserMode();
        force dut.prev_mode = 1'b0;
        m_prev = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        release dut.prev_mode;
        idleCycle();
        compare("user_mode_entered", 32'(Mode), 32'h0);
    endtask

    typedef struct {
        logic        ipc, imem, sys, er;
        logic [15:0] pc;
        logic        mode, flush, redir;
        logic [15:0] rpc, epc;
        logic [1:0]  cause;
    } vec_t;

    vec_t tbl [23];

    initial begin
        tbl[0]  = '{0,1,0,0,16'h1234, 1,1,0,16'h0000,16'h1234,2'd1};
        tbl[1]  = '{0,0,0,0,16'h0000, 1,1,0,16'h0000,16'h1234,2'd1};
        tbl[2]  = '{0,0,0,0,16'h0000, 1,1,1,16'h0020,16'h1234,2'd1};
        tbl[3]  = '{0,0,0,0,16'h0000, 1,0,0,16'h0020,16'h1234,2'd1};
        tbl[4]  = '{0,0,0,1,16'h0000, 0,1,1,16'h1234,16'h1234,2'd1};
        tbl[5]  = '{0,0,0,0,16'h0000, 0,0,0,16'h1234,16'h1234,2'd1};
        tbl[6]  = '{1,1,0,0,16'h2000, 1,1,0,16'h1234,16'h2000,2'd0};
        tbl[7]  = '{0,0,1,0,16'h0000, 1,1,0,16'h1234,16'h2000,2'd0};
        tbl[8]  = '{0,0,0,0,16'h0000, 1,1,1,16'h0010,16'h2000,2'd0};
        tbl[9]  = '{0,1,0,0,16'h5555, 1,0,0,16'h0010,16'h2000,2'd0};
        tbl[10] = '{0,0,0,0,16'h0000, 1,0,0,16'h0010,16'h2000,2'd0};
        tbl[11] = '{0,0,0,1,16'h0000, 0,1,1,16'h2000,16'h2000,2'd0};
        tbl[12] = '{0,0,0,0,16'h0000, 0,0,0,16'h2000,16'h2000,2'd0};
        tbl[13] = '{0,0,0,1,16'h3004, 1,1,0,16'h2000,16'h3004,2'd3};
        tbl[14] = '{0,0,0,0,16'h0000, 1,1,0,16'h2000,16'h3004,2'd3};
        tbl[15] = '{0,0,0,0,16'h0000, 1,1,1,16'h0040,16'h3004,2'd3};
        tbl[16] = '{0,0,0,0,16'h0000, 1,0,0,16'h0040,16'h3004,2'd3};
        tbl[17] = '{0,0,1,1,16'h4000, 1,1,0,16'h0040,16'h4000,2'd2};
        tbl[18] = '{0,0,0,0,16'h0000, 1,1,0,16'h0040,16'h4000,2'd2};
        tbl[19] = '{0,0,0,0,16'h0000, 1,1,1,16'h0030,16'h4000,2'd2};
        tbl[20] = '{0,0,0,0,16'h0000, 1,0,0,16'h0030,16'h4000,2'd2};
        tbl[21] = '{0,0,0,1,16'h0000, 1,1,1,16'h4000,16'h4000,2'd2};
        tbl[22] = '{0,0,0,0,16'h0000, 1,0,0,16'h4000,16'h4000,2'd2};

        modelReset();
        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        compare("reset_mode", 32'(Mode), 32'h1);
        compare("reset_busy", 32'(busy), 32'h0);
        compare("reset_redirect_pc", 32'(redirect_pc), 32'h0);

        enterUserMode();

        $display("[TB] directed vector table");
        for (int i = 0; i < 23; i++) begin
            applyStimulus(1'b0, tbl[i].ipc, tbl[i].imem, tbl[i].sys, tbl[i].er, tbl[i].pc);
            compare($sformatf("tbl%0d_mode", i), 32'(Mode), 32'(tbl[i].mode));
            compare($sformatf("tbl%0d_flush", i), 32'(trap_flush), 32'(tbl[i].flush));
            compare($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].flush));
            compare($sformatf("tbl%0d_redir", i), 32'(pc_redirect), 32'(tbl[i].redir));
            compare($sformatf("tbl%0d_rpc", i), 32'(redirect_pc), 32'(tbl[i].rpc));
            compare($sformatf("tbl%0d_epc", i), 32'(epc), 32'(tbl[i].epc));
            compare($sformatf("tbl%0d_cause", i), 32'(cause), 32'(tbl[i].cause));
        end

        $display("[TB] reset during second flush cycle");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7777);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        compare("rstflush_mode", 32'(Mode), 32'h1);
        compare("rstflush_busy", 32'(busy), 32'h0);
        compare("rstflush_flush", 32'(trap_flush), 32'h0);
        compare("rstflush_epc", 32'(epc), 32'h0);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            compare("rstflush_no_redirect", 32'(pc_redirect), 32'h0);
        end

        $display("[TB] random stimulus");
        enterUserMode();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                          16'($urandom));
        end

        $display("[TB] trap counter saturation");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(i));
            for (int j = 0; j < FC + 1; j++) idleCycle();
        end
        compare("trap_count_saturated", 32'(trap_count), 32'(EXP_SAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
